counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter: DIV, 4, clock cycles per count step; legal range 1..255.
REQ-002 Port: CLK  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: iStart  input  1  level; request run.
REQ-005 Port: iStop  input  1  level; request pause.
REQ-006 Port: iClear  input  1  level; force count to 0 and go idle.
REQ-007 Port: iLoad  input  1  level; load iLoadVal and go idle.
REQ-008 Port: iLoadVal  input  3  value loaded by iLoad.
REQ-009 Port: iUp  input  1  direction: 1 = up, 0 = down; sampled on every step.
REQ-010 Port: iOneShot  input  1  1 = stop at iTarget; 0 = free-run.
REQ-011 Port: iTarget  input  3  one-shot terminal value.
REQ-012 Port: oQ  output  3  registered mod-8 count.
REQ-013 Port: oDisplay  output  7  seven-segment pattern of oQ, active-low, bit order {g,f,e,d,c,b,a}.
REQ-014 Port: oRunning  output  1  high while state is RUN.
REQ-015 Port: oDone  output  1  high while state is DONE.
REQ-016 Port: oTick  output  1  one-cycle pulse, high in the cycle after every edge that changes oQ by a step.

Function
REQ-017 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-018 Command priority SHALL be iClear > iLoad > iStop > iStart; only the highest asserted command acts in a cycle.
REQ-019 iClear in any state SHALL set oQ=0, prescaler=0, state=IDLE at the next edge.
REQ-020 iLoad in any state SHALL set oQ=iLoadVal, prescaler=0, state=IDLE at the next edge.
REQ-021 iStart in IDLE or DONE SHALL enter RUN with prescaler=0; iStart in PAUSE SHALL enter RUN with the prescaler value retained.
REQ-022 iStop in RUN SHALL enter PAUSE with prescaler and oQ frozen; iStop in other states has no effect.
REQ-023 In RUN, the prescaler SHALL count 0..DIV-1; on the edge where it equals DIV-1, it returns to 0 and oQ steps; first step therefore occurs DIV edges after entering RUN from IDLE.
REQ-024 A step SHALL be oQ+1 mod 8 when iUp=1 (7 wraps to 0) and oQ-1 mod 8 when iUp=0 (0 wraps to 7).
REQ-025 With iOneShot=1, a step whose new value equals iTarget SHALL move the state to DONE on that same edge; the target is checked only after a step, so starting with oQ==iTarget runs a full 8-step lap.
REQ-026 DONE SHALL hold oQ; only iClear, iLoad or iStart leave DONE.
REQ-027 oTick SHALL be a registered pulse: high for exactly one cycle following each step edge, never on clear or load.
REQ-028 With DIV=1, oQ SHALL step on every edge in RUN and oTick SHALL stay high continuously.
REQ-029 iStop and a step-due prescaler in the same cycle: iStop wins, no step occurs.

Reset
REQ-030 While rst=1: state=IDLE, oQ=0, prescaler=0, oRunning=0, oDone=0, oTick=0, oDisplay=7'b1000000 (or 7'b1111111 per REQ-032); deassertion takes effect at the next edge.
REQ-031 Reset asserted mid-RUN SHALL immediately abort the run with no further step.

Configuration
REQ-032 Macro COUNTER_CTRL_DISPLAY_EN: defined -> oDisplay decodes oQ 0..7 as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, combinationally from oQ; undefined -> no decoder is built and oDisplay is constant 1111111 (blank).

Verification
REQ-033 DIV=4, reset, iUp=1, pulse iStart one cycle -> oQ steps 0,1,...,7,0 every 4 cycles; oTick pulses 9 times over 36 cycles; oRunning=1 throughout.
REQ-034 iLoad with iLoadVal=2, then iUp=0, iStart -> oQ sequence 1,0,7,6; wrap 0->7 observed.
REQ-035 iOneShot=1, iTarget=5, from oQ=0 run up -> oQ stops at 5, oDone=1, oRunning=0, no further oTick for 20 cycles.
REQ-036 Run to oQ=3, iStop and iStart asserted together -> PAUSE entered, oQ=3 frozen; later iStart alone -> next step after the remaining prescaler count, not a full DIV.
REQ-037 Assert rst asynchronously mid-RUN at oQ=6 -> oQ=0, oRunning=0 before the next CLK edge; oDisplay=1000000 with COUNTER_CTRL_DISPLAY_EN, 1111111 without.
REQ-038 DIV=1, iClear and iLoad asserted together in RUN -> oQ=0, state IDLE, no oTick.

Source files
------------

// File: rtl/counter_ctrl.sv
// Prescaled mod-8 up/down counter with run/pause/one-shot control FSM.
// Optional seven-segment decoder enabled by COUNTER_CTRL_DISPLAY_EN (blank otherwise).
module counter_ctrl #(
    parameter int unsigned DIV = 4
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       iStart,
    input  logic       iStop,
    input  logic       iClear,
    input  logic       iLoad,
    input  logic [2:0] iLoadVal,
    input  logic       iUp,
    input  logic       iOneShot,
    input  logic [2:0] iTarget,
    output logic [2:0] oQ,
    output logic [6:0] oDisplay,
    output logic       oRunning,
    output logic       oDone,
    output logic       oTick
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    localparam logic [7:0] PreMax = 8'(DIV - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] pre_q, pre_d;
    logic       tick_q, tick_d;
    logic [2:0] step_val;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            pre_q   <= 8'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
        end
    end

    assign step_val = iUp ? cnt_q + 3'd1 : cnt_q - 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        if (iClear) begin
            cnt_d   = 3'd0;
            pre_d   = 8'd0;
            state_d = StIdle;
        end else if (iLoad) begin
            cnt_d   = iLoadVal;
            pre_d   = 8'd0;
            state_d = StIdle;
        end else if (iStop) begin
            // Stop outranks a due step; outside RUN it simply masks iStart.
            if (state_q == StRun) begin
                state_d = StPause;
            end
        end else if (iStart && (state_q != StRun)) begin
            state_d = StRun;
            if (state_q != StPause) begin
                pre_d = 8'd0;
            end
        end else if (state_q == StRun) begin
            if (pre_q == PreMax) begin
                pre_d  = 8'd0;
                cnt_d  = step_val;
                tick_d = 1'b1;
                if (iOneShot && (step_val == iTarget)) begin
                    state_d = StDone;
                end
            end else begin
                pre_d = pre_q + 8'd1;
            end
        end
    end

    assign oQ       = cnt_q;
    assign oRunning = (state_q == StRun);
    assign oDone    = (state_q == StDone);
    assign oTick    = tick_q;

`ifdef COUNTER_CTRL_DISPLAY_EN
    always_comb begin
        oDisplay = 7'b1111111;
        case (cnt_q)
            3'd0:    oDisplay = 7'b1000000;
            3'd1:    oDisplay = 7'b1111001;
            3'd2:    oDisplay = 7'b0100100;
            3'd3:    oDisplay = 7'b0110000;
            3'd4:    oDisplay = 7'b0011001;
            3'd5:    oDisplay = 7'b0010010;
            3'd6:    oDisplay = 7'b0000010;
            default: oDisplay = 7'b1111000;
        endcase
    end
`else
    assign oDisplay = 7'b1111111;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed vector table plus multi-cycle sequences.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, clr, load, up, oneshot;
    logic [2:0] ldval, target;

    logic [2:0] q4, q1;
    logic [6:0] disp4, disp1;
    logic       run4, run1, done4, done1, tick4, tick1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    counter_ctrl #(.DIV(4)) dut4 (
        .CLK(clk), .rst(rst), .iStart(start), .iStop(stop), .iClear(clr), .iLoad(load),
        .iLoadVal(ldval), .iUp(up), .iOneShot(oneshot), .iTarget(target),
        .oQ(q4), .oDisplay(disp4), .oRunning(run4), .oDone(done4), .oTick(tick4)
    );

    counter_ctrl #(.DIV(1)) dut1 (
        .CLK(clk), .rst(rst), .iStart(start), .iStop(stop), .iClear(clr), .iLoad(load),
        .iLoadVal(ldval), .iUp(up), .iOneShot(oneshot), .iTarget(target),
        .oQ(q1), .oDisplay(disp1), .oRunning(run1), .oDone(done1), .oTick(tick1)
    );

    typedef struct packed {
        logic       clr;
        logic       load;
        logic [2:0] ldval;
        logic       stop;
        logic       start;
        logic       up;
        logic [2:0] q;
        logic       run;
        logic       done;
        logic       tick;
    } vec_t;

    vec_t vecs [0:15];

    function automatic logic [6:0] exp_disp(input logic [2:0] v);
`ifdef COUNTER_CTRL_DISPLAY_EN
        case (v)
            3'd0:    return 7'b1000000;
            3'd1:    return 7'b1111001;
            3'd2:    return 7'b0100100;
            3'd3:    return 7'b0110000;
            3'd4:    return 7'b0011001;
            3'd5:    return 7'b0010010;
            3'd6:    return 7'b0000010;
            default: return 7'b1111000;
        endcase
`else
        return 7'b1111111;
`endif
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        clr = 0; load = 0; stop = 0; start = 0;
    endtask

    task automatic cmd(input logic c, input logic l, input logic s, input logic g);
        clr = c; load = l; stop = s; start = g;
        cyc();
        idle_in();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks;
        rst = 1; idle_in(); ldval = 0; up = 1; oneshot = 0; target = 0;
        vecs[0]  = '{1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};

        // Reset state
        wait_cycles(2);
        check("rst_q", 8'(q4), 8'd0);
        check("rst_run", 8'(run4), 8'd0);
        check("rst_done", 8'(done4), 8'd0);
        check("rst_tick", 8'(tick4), 8'd0);
        check("rst_disp", 8'(disp4), 8'(exp_disp(3'd0)));
        check("rst_disp_div1", 8'(disp1), 8'(exp_disp(3'd0)));
        rst = 0;
        cyc();

        // Vector table: load, down step, pause/resume with retained prescaler, priorities
        for (int i = 0; i < 16; i++) begin
            clr = vecs[i].clr; load = vecs[i].load; ldval = vecs[i].ldval;
            stop = vecs[i].stop; start = vecs[i].start; up = vecs[i].up;
            cyc();
            check($sformatf("vec%0d_q", i), 8'(q4), 8'(vecs[i].q));
            check($sformatf("vec%0d_run", i), 8'(run4), 8'(vecs[i].run));
            check($sformatf("vec%0d_done", i), 8'(done4), 8'(vecs[i].done));
            check($sformatf("vec%0d_tick", i), 8'(tick4), 8'(vecs[i].tick));
            check($sformatf("vec%0d_disp", i), 8'(disp4), 8'(exp_disp(vecs[i].q)));
        end
        idle_in();

        // Full up-count lap: step every 4 edges, 9 ticks over 36 cycles
        up = 1;
        cmd(1, 0, 0, 0);
        cmd(0, 0, 0, 1);
        ticks = 0;
        for (int k = 1; k <= 36; k++) begin
            cyc();
            if (tick4) ticks++;
            check($sformatf("lap_q_%0d", k), 8'(q4), 8'((k / 4) % 8));
            check($sformatf("lap_run_%0d", k), 8'(run4), 8'd1);
        end
        check("lap_ticks", 8'(ticks), 8'd9);

        // Down count with 0->7 wrap
        ldval = 3'd2; up = 0;
        cmd(0, 1, 0, 0);
        cmd(0, 0, 0, 1);
        wait_cycles(4);  check("down_1", 8'(q4), 8'd1);
        wait_cycles(4);  check("down_0", 8'(q4), 8'd0);
        wait_cycles(4);  check("down_7", 8'(q4), 8'd7);
        wait_cycles(4);  check("down_6", 8'(q4), 8'd6);

        // One-shot to target 5
        up = 1; oneshot = 1; target = 3'd5;
        cmd(1, 0, 0, 0);
        cmd(0, 0, 0, 1);
        wait_cycles(16); check("os_q4_running", 8'(run4), 8'd1);
        wait_cycles(4);
        check("os_q", 8'(q4), 8'd5);
        check("os_done", 8'(done4), 8'd1);
        check("os_run", 8'(run4), 8'd0);
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (tick4) ticks++;
        end
        check("os_no_tick", 8'(ticks), 8'd0);
        check("os_hold", 8'(q4), 8'd5);

        // One-shot starting at target: full 8-step lap
        ldval = 3'd5;
        cmd(0, 1, 0, 0);
        cmd(0, 0, 0, 1);
        wait_cycles(28); check("lap_os_q4", 8'(q4), 8'd4);
        check("lap_os_notdone", 8'(done4), 8'd0);
        wait_cycles(4);  check("lap_os_q5", 8'(q4), 8'd5);
        check("lap_os_done", 8'(done4), 8'd1);
        oneshot = 0;

        // Stop+start together at q=3, resume after remaining prescaler
        cmd(1, 0, 0, 0);
        cmd(0, 0, 0, 1);
        wait_cycles(12); check("ss_q3", 8'(q4), 8'd3);
        wait_cycles(2);
        cmd(0, 0, 1, 1);
        check("ss_pause_run", 8'(run4), 8'd0);
        wait_cycles(3);  check("ss_frozen", 8'(q4), 8'd3);
        cmd(0, 0, 0, 1);
        check("ss_resume_run", 8'(run4), 8'd1);
        cyc();           check("ss_not_yet", 8'(q4), 8'd3);
        cyc();           check("ss_step", 8'(q4), 8'd4);
        check("ss_tick", 8'(tick4), 8'd1);
        // Stop on a step-due edge: no step
        wait_cycles(3);
        cmd(0, 0, 1, 0);
        check("sd_q", 8'(q4), 8'd4);
        check("sd_tick", 8'(tick4), 8'd0);
        cmd(0, 0, 0, 1);
        cyc();           check("sd_resume_step", 8'(q4), 8'd5);

        // Asynchronous reset mid-run at q=6
        cmd(1, 0, 0, 0);
        cmd(0, 0, 0, 1);
        wait_cycles(24); check("ar_q6", 8'(q4), 8'd6);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("ar_q", 8'(q4), 8'd0);
        check("ar_run", 8'(run4), 8'd0);
        check("ar_tick", 8'(tick4), 8'd0);
        check("ar_disp", 8'(disp4), 8'(exp_disp(3'd0)));
        wait_cycles(2);
        check("ar_hold", 8'(q4), 8'd0);
        rst = 0;
        cyc();

        // DIV=1: step every edge, tick continuous; clear+load gives 0, idle, no tick
        cmd(1, 0, 0, 0);
        cmd(0, 0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check($sformatf("d1_q_%0d", k), 8'(q1), 8'(k));
            check($sformatf("d1_tick_%0d", k), 8'(tick1), 8'd1);
        end
        ldval = 3'd5;
        cmd(1, 1, 0, 0);
        check("d1_cl_q", 8'(q1), 8'd0);
        check("d1_cl_run", 8'(run1), 8'd0);
        check("d1_cl_done", 8'(done1), 8'd0);
        check("d1_cl_tick", 8'(tick1), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
